// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave -- AXI4 slave backed by a 64-bit word memory, one burst at a time.
// Optional macro AXI_MEM_RANGE_CHECK_EN: out-of-range beats get SLVERR instead of wrapping.
module axi4_mem_slave #(
    parameter int          DEPTH     = 8192,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  S_AXI_AWID,
    input  logic [63:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWLOCK,
    input  logic [3:0]  S_AXI_AWCACHE,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic [3:0]  S_AXI_AWQOS,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [63:0] S_AXI_WDATA,
    input  logic [7:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [3:0]  S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [3:0]  S_AXI_ARID,
    input  logic [63:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARLOCK,
    input  logic [3:0]  S_AXI_ARCACHE,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic [3:0]  S_AXI_ARQOS,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [3:0]  S_AXI_RID,
    output logic [63:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_mem [DEPTH];
    logic        r_prio_wr;
    logic [3:0]  r_id;
    logic [63:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic [1:0]  r_burst;
    logic        r_werr;
    logic        r_bvalid;
    logic [3:0]  r_bid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [63:0] r_rdata;
    logic [3:0]  r_rid;
    logic [1:0]  r_rresp;
    logic        r_rlast;

    logic          w_awready;
    logic          w_arready;
    logic          w_wready;
    logic          w_sel_wr;
    logic          w_sel_rd;
    logic          w_aw_hs;
    logic          w_ar_hs;
    logic          w_w_hs;
    logic          w_b_hs;
    logic          w_r_hs;
    logic          w_wr_last;
    logic [63:0]   w_addr_adv;
    logic [63:0]   w_rd_addr;
    logic [63:0]   w_wr_diff;
    logic [63:0]   w_rd_diff;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [63:0]   w_rd_word;
    logic          w_unused;

    // Write wins a tie when it holds priority; priority flips on every grant.
    assign w_sel_wr = S_AXI_AWVALID & (~S_AXI_ARVALID | r_prio_wr);
    assign w_sel_rd = S_AXI_ARVALID & ~w_sel_wr;

    assign w_aw_hs   = w_awready & S_AXI_AWVALID;
    assign w_ar_hs   = w_arready & S_AXI_ARVALID;
    assign w_w_hs    = w_wready & S_AXI_WVALID;
    assign w_b_hs    = r_bvalid & S_AXI_BREADY;
    assign w_r_hs    = r_rvalid & S_AXI_RREADY;
    assign w_wr_last = (r_cnt == r_len);

    // FIXED bursts hold the address; INCR and WRAP step one word per beat.
    assign w_addr_adv = (r_burst == 2'b00) ? r_addr : r_addr + 64'd8;
    assign w_rd_addr  = (r_state == IDLE) ? S_AXI_ARADDR : w_addr_adv;
    assign w_wr_diff  = r_addr - BASE_ADDR;
    assign w_rd_diff  = w_rd_addr - BASE_ADDR;
    assign w_wr_idx   = w_wr_diff[AW+2:3];
    assign w_rd_idx   = w_rd_diff[AW+2:3];

`ifdef AXI_MEM_RANGE_CHECK_EN
    assign w_wr_ok  = (w_wr_diff[63:AW+3] == '0);
    assign w_rd_ok  = (w_rd_diff[63:AW+3] == '0);
    assign w_unused = ^{w_wr_diff[2:0], w_rd_diff[2:0],
                        S_AXI_AWSIZE, S_AXI_AWLOCK, S_AXI_AWCACHE,
                        S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_WLAST,
                        S_AXI_ARSIZE, S_AXI_ARLOCK, S_AXI_ARCACHE,
                        S_AXI_ARPROT, S_AXI_ARQOS};
`else
    assign w_wr_ok  = 1'b1;
    assign w_rd_ok  = 1'b1;
    assign w_unused = ^{w_wr_diff[2:0], w_rd_diff[2:0],
                        w_wr_diff[63:AW+3], w_rd_diff[63:AW+3],
                        S_AXI_AWSIZE, S_AXI_AWLOCK, S_AXI_AWCACHE,
                        S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_WLAST,
                        S_AXI_ARSIZE, S_AXI_ARLOCK, S_AXI_ARCACHE,
                        S_AXI_ARPROT, S_AXI_ARQOS};
`endif

    assign w_rd_word = w_rd_ok ? r_mem[w_rd_idx] : 64'd0;

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BID     = r_bid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RID     = r_rid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RLAST   = r_rlast;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state and channel readies; readies are held low during reset.
    always_comb begin
        w_state_nxt = r_state;
        w_awready   = 1'b0;
        w_arready   = 1'b0;
        w_wready    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_awready = rst_ni & w_sel_wr;
                w_arready = rst_ni & w_sel_rd;
                if (w_aw_hs)      w_state_nxt = WDATA;
                else if (w_ar_hs) w_state_nxt = RDATA;
            end
            WDATA: begin
                w_wready = rst_ni;
                if (w_w_hs && w_wr_last) w_state_nxt = WRESP;
            end
            WRESP: begin
                if (w_b_hs) w_state_nxt = IDLE;
            end
            RDATA: begin
                if (w_r_hs && r_rlast) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Burst bookkeeping plus the registered B and R channel outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_prio_wr <= 1'b1;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_burst   <= '0;
            r_werr    <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= OKAY;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rid     <= '0;
            r_rresp   <= OKAY;
            r_rlast   <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_prio_wr <= 1'b0;
                r_id      <= S_AXI_AWID;
                r_addr    <= S_AXI_AWADDR;
                r_len     <= S_AXI_AWLEN;
                r_burst   <= S_AXI_AWBURST;
                r_cnt     <= '0;
                r_werr    <= 1'b0;
            end
            if (w_ar_hs) begin
                r_prio_wr <= 1'b1;
                r_id      <= S_AXI_ARID;
                r_addr    <= S_AXI_ARADDR;
                r_len     <= S_AXI_ARLEN;
                r_burst   <= S_AXI_ARBURST;
                r_cnt     <= '0;
                r_rvalid  <= 1'b1;
                r_rid     <= S_AXI_ARID;
                r_rdata   <= w_rd_word;
                r_rresp   <= w_rd_ok ? OKAY : SLVERR;
                r_rlast   <= (S_AXI_ARLEN == 8'd0);
            end
            if (w_w_hs) begin
                r_addr <= w_addr_adv;
                r_cnt  <= r_cnt + 8'd1;
                r_werr <= r_werr | ~w_wr_ok;
                if (w_wr_last) begin
                    r_bvalid <= 1'b1;
                    r_bid    <= r_id;
                    r_bresp  <= (r_werr | ~w_wr_ok) ? SLVERR : OKAY;
                end
            end
            if (w_b_hs) begin
                r_bvalid <= 1'b0;
            end
            if (w_r_hs) begin
                if (r_rlast) begin
                    r_rvalid <= 1'b0;
                    r_rlast  <= 1'b0;
                end else begin
                    r_addr  <= w_addr_adv;
                    r_cnt   <= r_cnt + 8'd1;
                    r_rdata <= w_rd_word;
                    r_rresp <= w_rd_ok ? OKAY : SLVERR;
                    r_rlast <= (r_cnt + 8'd1 == r_len);
                end
            end
        end
    end

    // Byte-enabled memory write; no reset so contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (w_w_hs && w_wr_ok) begin
            for (int b = 0; b < 8; b++) begin
                if (S_AXI_WSTRB[b]) r_mem[w_wr_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb_axi4_mem_slave -- directed bench for axi4_mem_slave.
// Range-check expectations follow AXI_MEM_RANGE_CHECK_EN.
module tb_axi4_mem_slave;

    localparam int          DEPTH = 8192;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awid = '0;
    logic [63:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'd3;
    logic [1:0]  awburst = 2'b01;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  arid = '0;
    logic [63:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd3;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] wbuf [256];
    logic [7:0]  sbuf [256];
    logic [63:0] rbuf [256];
    logic        lbuf [256];
    logic [1:0]  pbuf [256];
    logic [3:0]  ibuf [256];
    logic [3:0]  got_bid;
    logic [1:0]  got_bresp;
    int          got_beats;

    always #5 clk = ~clk;

    axi4_mem_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0),
        .S_AXI_AWQOS(4'd0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0),
        .S_AXI_ARQOS(4'd0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic aw_req(input logic [3:0] id, input logic [63:0] a,
                          input logic [7:0] len, input logic [1:0] bt);
        awid = id; awaddr = a; awlen = len; awburst = bt; awvalid = 1'b1;
    endtask

    task automatic ar_req(input logic [3:0] id, input logic [63:0] a,
                          input logic [7:0] len, input logic [1:0] bt);
        arid = id; araddr = a; arlen = len; arburst = bt; arvalid = 1'b1;
    endtask

    task automatic aw_wait();
        int k = 0;
        #1;
        while (awready !== 1'b1 && k < 100) begin @(negedge clk); #1; k++; end
        n_cmp++;
        if (awready !== 1'b1) begin
            n_err++;
            $display("FAIL aw_accept: awready=%b required 1", awready);
        end
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic ar_wait();
        int k = 0;
        #1;
        while (arready !== 1'b1 && k < 100) begin @(negedge clk); #1; k++; end
        n_cmp++;
        if (arready !== 1'b1) begin
            n_err++;
            $display("FAIL ar_accept: arready=%b required 1", arready);
        end
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic w_b_phase(input int len, input int hold);
        int k;
        for (int b = 0; b <= len; b++) begin
            wvalid = 1'b1; wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == len);
            k = 0;
            #1;
            while (wready !== 1'b1 && k < 100) begin @(negedge clk); #1; k++; end
            n_cmp++;
            if (wready !== 1'b1) begin
                n_err++;
                $display("FAIL w_accept beat %0d: wready=%b required 1", b, wready);
            end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        n_cmp++;
        if (bvalid !== 1'b1) begin
            n_err++;
            $display("FAIL bvalid_next: bvalid=%b required 1", bvalid);
        end
        k = 0;
        while (bvalid !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        got_bid = bid; got_bresp = bresp;
        repeat (hold) begin
            @(negedge clk);
            n_cmp++;
            if (bvalid !== 1'b1 || bid !== got_bid || bresp !== got_bresp) begin
                n_err++;
                $display("FAIL b_hold: bvalid=%b bid=%h bresp=%b required 1 %h %b",
                         bvalid, bid, bresp, got_bid, got_bresp);
            end
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        n_cmp++;
        if (bvalid !== 1'b0) begin
            n_err++;
            $display("FAIL b_clear: bvalid=%b required 0", bvalid);
        end
    endtask

    task automatic r_phase(input int len, input bit rnd);
        int k = 0;
        int nb = 0;
        bit st = 1'b0;
        bit dead = 1'b0;
        logic [63:0] pd = '0;
        logic pl = 1'b0;
        logic [1:0] pr = '0;
        logic [3:0] pi = '0;
        while (nb <= len && k < 5000 && !dead) begin
            if (rvalid !== 1'b1) begin
                n_cmp++; n_err++;
                $display("FAIL rvalid_beat %0d: rvalid=%b required 1", nb, rvalid);
                dead = 1'b1;
            end else begin
                if (st) begin
                    n_cmp++;
                    if (rdata !== pd || rlast !== pl || rresp !== pr || rid !== pi) begin
                        n_err++;
                        $display("FAIL r_stable beat %0d: got %h/%b/%b/%h required %h/%b/%b/%h",
                                 nb, rdata, rlast, rresp, rid, pd, pl, pr, pi);
                    end
                end
                rready = (rnd && (k % 3 == 0 || $urandom_range(0, 3) == 0)) ? 1'b0 : 1'b1;
                if (rready) begin
                    rbuf[nb] = rdata; lbuf[nb] = rlast; pbuf[nb] = rresp; ibuf[nb] = rid;
                    nb++;
                    st = 1'b0;
                end else begin
                    st = 1'b1; pd = rdata; pl = rlast; pr = rresp; pi = rid;
                end
                @(negedge clk);
                k++;
            end
        end
        rready = 1'b0;
        got_beats = nb;
        n_cmp++;
        if (rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL r_end: rvalid=%b required 0 after last beat", rvalid);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [63:0] a,
                            input logic [7:0] len, input logic [1:0] bt, input int hold);
        aw_req(id, a, len, bt);
        aw_wait();
        w_b_phase(int'(len), hold);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [63:0] a,
                           input logic [7:0] len, input logic [1:0] bt, input bit rnd);
        ar_req(id, a, len, bt);
        ar_wait();
        r_phase(int'(len), rnd);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        awvalid = 1'b1; arvalid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({awready, arready, wready, bvalid, rvalid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_handshake: aw/ar/w/b/r=%b required 00000",
                     {awready, arready, wready, bvalid, rvalid});
        end
        n_cmp++;
        if (bid !== 4'd0 || rid !== 4'd0 || bresp !== 2'd0 || rresp !== 2'd0) begin
            n_err++;
            $display("FAIL reset_ids: bid=%h rid=%h bresp=%b rresp=%b required 0",
                     bid, rid, bresp, rresp);
        end
        n_cmp++;
        if (rdata !== 64'd0 || rlast !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rdata: rdata=%h rlast=%b required 0", rdata, rlast);
        end
        awvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_incr_burst();
        for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i + 1); sbuf[i] = 8'hFF; end
        do_write(4'h5, BASE, 8'd3, 2'b01, 2);
        n_cmp++;
        if (got_bid !== 4'h5 || got_bresp !== 2'b00) begin
            n_err++;
            $display("FAIL incr_bresp: bid=%h bresp=%b required 5 00", got_bid, got_bresp);
        end
        do_read(4'h9, BASE, 8'd3, 2'b01, 1'b0);
        n_cmp++;
        if (got_beats != 4) begin
            n_err++;
            $display("FAIL incr_beats: got %0d required 4", got_beats);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rbuf[i] !== 64'(i + 1) || lbuf[i] !== (i == 3) || pbuf[i] !== 2'b00 || ibuf[i] !== 4'h9) begin
                n_err++;
                $display("FAIL incr_beat%0d: data=%h last=%b resp=%b id=%h required %h %b 00 9",
                         i, rbuf[i], lbuf[i], pbuf[i], ibuf[i], 64'(i + 1), (i == 3));
            end
        end
    endtask

    task automatic test_strobe();
        wbuf[0] = 64'h1111_2222_3333_4444; sbuf[0] = 8'hFF;
        do_write(4'h1, BASE + 64'h100, 8'd0, 2'b01, 0);
        wbuf[0] = 64'hAAAA_BBBB_CCCC_DDDD; sbuf[0] = 8'h0F;
        do_write(4'h2, BASE + 64'h100, 8'd0, 2'b01, 0);
        do_read(4'h3, BASE + 64'h100, 8'd0, 2'b01, 1'b0);
        n_cmp++;
        if (rbuf[0] !== 64'h1111_2222_CCCC_DDDD || lbuf[0] !== 1'b1) begin
            n_err++;
            $display("FAIL strobe: data=%h last=%b required 1111_2222_cccc_dddd 1", rbuf[0], lbuf[0]);
        end
    endtask

    task automatic test_fixed();
        wbuf[0] = 64'h10; wbuf[1] = 64'h20; wbuf[2] = 64'h30;
        for (int i = 0; i < 3; i++) sbuf[i] = 8'hFF;
        do_write(4'h4, BASE + 64'h200, 8'd2, 2'b00, 0);
        do_read(4'h4, BASE + 64'h200, 8'd1, 2'b00, 1'b0);
        n_cmp++;
        if (got_beats != 2 || rbuf[0] !== 64'h30 || rbuf[1] !== 64'h30) begin
            n_err++;
            $display("FAIL fixed: beats=%0d data=%h,%h required 2 30,30", got_beats, rbuf[0], rbuf[1]);
        end
    endtask

    task automatic test_arbitration();
        logic [63:0] x;
        x = BASE + 64'h300;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wbuf[0] = 64'hA0; sbuf[0] = 8'hFF;
        aw_req(4'h1, x, 8'd0, 2'b01);
        ar_req(4'h2, x, 8'd0, 2'b01);
        #1;
        n_cmp++;
        if (awready !== 1'b1 || arready !== 1'b0) begin
            n_err++;
            $display("FAIL arb_0: aw/ar ready=%b%b required 10", awready, arready);
        end
        aw_wait();
        w_b_phase(0, 0);
        wbuf[0] = 64'hB1;
        aw_req(4'h3, x, 8'd0, 2'b01);
        #1;
        n_cmp++;
        if (awready !== 1'b0 || arready !== 1'b1) begin
            n_err++;
            $display("FAIL arb_1: aw/ar ready=%b%b required 01", awready, arready);
        end
        ar_wait();
        r_phase(0, 1'b0);
        n_cmp++;
        if (rbuf[0] !== 64'hA0 || ibuf[0] !== 4'h2) begin
            n_err++;
            $display("FAIL arb_1_data: data=%h id=%h required a0 2", rbuf[0], ibuf[0]);
        end
        ar_req(4'h4, x, 8'd0, 2'b01);
        #1;
        n_cmp++;
        if (awready !== 1'b1 || arready !== 1'b0) begin
            n_err++;
            $display("FAIL arb_2: aw/ar ready=%b%b required 10", awready, arready);
        end
        aw_wait();
        w_b_phase(0, 0);
        wbuf[0] = 64'hC2;
        aw_req(4'h5, x + 64'h8, 8'd0, 2'b01);
        #1;
        n_cmp++;
        if (awready !== 1'b0 || arready !== 1'b1) begin
            n_err++;
            $display("FAIL arb_3: aw/ar ready=%b%b required 01", awready, arready);
        end
        ar_wait();
        r_phase(0, 1'b0);
        n_cmp++;
        if (rbuf[0] !== 64'hB1 || ibuf[0] !== 4'h4) begin
            n_err++;
            $display("FAIL arb_3_data: data=%h id=%h required b1 4", rbuf[0], ibuf[0]);
        end
        aw_wait();
        w_b_phase(0, 0);
        n_cmp++;
        if (got_bid !== 4'h5) begin
            n_err++;
            $display("FAIL arb_4_bid: bid=%h required 5", got_bid);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 16; i++) begin wbuf[i] = {32'hCAFE_0000, 32'(i)}; sbuf[i] = 8'hFF; end
        do_write(4'h6, BASE + 64'h400, 8'd15, 2'b01, 0);
        do_read(4'hA, BASE + 64'h400, 8'd15, 2'b01, 1'b1);
        n_cmp++;
        if (got_beats != 16) begin
            n_err++;
            $display("FAIL stall_beats: got %0d required 16", got_beats);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (rbuf[i] !== {32'hCAFE_0000, 32'(i)} || lbuf[i] !== (i == 15) || ibuf[i] !== 4'hA) begin
                n_err++;
                $display("FAIL stall_beat%0d: data=%h last=%b id=%h required %h %b a",
                         i, rbuf[i], lbuf[i], ibuf[i], {32'hCAFE_0000, 32'(i)}, (i == 15));
            end
        end
    endtask

    task automatic test_len256();
        for (int i = 0; i < 256; i++) begin wbuf[i] = 64'h7700_0000 + 64'(i); sbuf[i] = 8'hFF; end
        do_write(4'h7, BASE + 64'h1000, 8'd255, 2'b01, 0);
        do_read(4'h7, BASE + 64'h1000, 8'd255, 2'b01, 1'b0);
        n_cmp++;
        if (got_beats != 256) begin
            n_err++;
            $display("FAIL len256_beats: got %0d required 256", got_beats);
        end
        for (int i = 0; i < 256; i++) begin
            n_cmp++;
            if (rbuf[i] !== 64'h7700_0000 + 64'(i) || lbuf[i] !== (i == 255)) begin
                n_err++;
                $display("FAIL len256_beat%0d: data=%h last=%b required %h %b",
                         i, rbuf[i], lbuf[i], 64'h7700_0000 + 64'(i), (i == 255));
            end
        end
    endtask

    task automatic test_reset_mid_read();
        for (int i = 0; i < 8; i++) begin wbuf[i] = 64'h5500 + 64'(i); sbuf[i] = 8'hFF; end
        do_write(4'h8, BASE + 64'h800, 8'd7, 2'b01, 0);
        ar_req(4'h6, BASE + 64'h800, 8'd7, 2'b01);
        ar_wait();
        rready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 64'd0 || rid !== 4'd0) begin
            n_err++;
            $display("FAIL midreset_r: rvalid=%b rlast=%b rdata=%h rid=%h required 0",
                     rvalid, rlast, rdata, rid);
        end
        rready = 1'b0;
        rst_n = 1'b1;
        do_read(4'hB, BASE + 64'h800, 8'd7, 2'b01, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (rbuf[i] !== 64'h5500 + 64'(i) || ibuf[i] !== 4'hB) begin
                n_err++;
                $display("FAIL midreset_beat%0d: data=%h id=%h required %h b",
                         i, rbuf[i], ibuf[i], 64'h5500 + 64'(i));
            end
        end
    endtask

    task automatic test_range();
        logic [63:0] oor;
        oor = BASE + 64'(DEPTH) * 64'd8;
        wbuf[0] = 64'hDEAD_BEEF_0000_0001; sbuf[0] = 8'hFF;
        do_write(4'hC, oor, 8'd0, 2'b01, 0);
`ifdef AXI_MEM_RANGE_CHECK_EN
        n_cmp++;
        if (got_bresp !== 2'b10) begin
            n_err++;
            $display("FAIL range_bresp: bresp=%b required 10", got_bresp);
        end
        do_read(4'hC, oor, 8'd0, 2'b01, 1'b0);
        n_cmp++;
        if (pbuf[0] !== 2'b10 || rbuf[0] !== 64'd0) begin
            n_err++;
            $display("FAIL range_rresp: resp=%b data=%h required 10 0", pbuf[0], rbuf[0]);
        end
        do_read(4'hC, BASE, 8'd0, 2'b01, 1'b0);
        n_cmp++;
        if (rbuf[0] !== 64'd1 || pbuf[0] !== 2'b00) begin
            n_err++;
            $display("FAIL range_word0: data=%h resp=%b required 1 00", rbuf[0], pbuf[0]);
        end
`else
        n_cmp++;
        if (got_bresp !== 2'b00) begin
            n_err++;
            $display("FAIL range_bresp: bresp=%b required 00", got_bresp);
        end
        do_read(4'hC, BASE, 8'd0, 2'b01, 1'b0);
        n_cmp++;
        if (rbuf[0] !== 64'hDEAD_BEEF_0000_0001 || pbuf[0] !== 2'b00) begin
            n_err++;
            $display("FAIL range_alias: data=%h resp=%b required deadbeef00000001 00", rbuf[0], pbuf[0]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_incr_burst();
        test_strobe();
        test_fixed();
        test_arbitration();
        test_stall();
        test_len256();
        test_reset_mid_read();
        test_range();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
